// File: rtl/vga_frame_reader.sv
// vga_frame_reader: raster scan of the 160x120 image RAM, 4x4 upscale,
// 640x480@60 VGA timing with a one-tick registered output stage.
module vga_frame_reader #(
  parameter int CLK_DIV     = 2,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SCALE_SHIFT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] pix_din,
  output logic [7:0] rd_x_addr,
  output logic [6:0] rd_y_addr,
  output logic [2:0] vga_rgb,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vblank,
  output logic       frame_done
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;

  logic [DIV_W-1:0] div_cnt;
  logic [H_W-1:0]   h_cnt;
  logic [V_W-1:0]   v_cnt;
  logic             tick;
  logic             h_last;
  logic             v_last;
  logic             active;
  logic             hs0;
  logic             vs0;

  assign tick   = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign h_last = (h_cnt == H_W'(H_TOTAL - 1));
  assign v_last = (v_cnt == V_W'(V_TOTAL - 1));
  assign active = (h_cnt < H_W'(H_ACTIVE)) &&
                  (v_cnt < V_W'(V_ACTIVE));

  // Pixel-rate divider: one tick every CLK_DIV clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Raster position: h advances per tick, v advances on h wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Stage 0: RAM address and raw syncs straight from the counters.
  always_comb begin
    rd_x_addr = '0;
    rd_y_addr = '0;
    if (active) begin
      rd_x_addr = 8'(h_cnt >> SCALE_SHIFT);
      rd_y_addr = 7'(v_cnt >> SCALE_SHIFT);
    end
    hs0 = !((h_cnt >= H_W'(HS_BEG)) && (h_cnt < H_W'(HS_END)));
    vs0 = !((v_cnt >= V_W'(VS_BEG)) && (v_cnt < V_W'(VS_END)));
  end

  assign vblank = (v_cnt >= V_W'(V_ACTIVE));

  // Stage 1: RAM data is a tick behind the address, so syncs and
  // blank are delayed by the same tick to stay aligned with rgb.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_rgb     <= 3'd0;
    end else if (tick) begin
      vga_hs      <= hs0;
      vga_vs      <= vs0;
      vga_blank_n <= active;
      vga_rgb     <= active ? pix_din : 3'd0;
    end
  end

  // End-of-frame pulse, one clk, as v moves into the first blank line.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= tick && h_last &&
                    (v_cnt == V_W'(V_ACTIVE - 1));
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: full-timing instance checked by table and
// sequences, a reduced-timing instance checked cycle by cycle vs a model.
module tb_vga_frame_reader;

  localparam int FD  = 2;
  localparam int SD  = 3;
  localparam int SHA = 64;
  localparam int SHF = 8;
  localparam int SHS = 12;
  localparam int SHB = 6;
  localparam int SVA = 24;
  localparam int SVF = 3;
  localparam int SVS = 2;
  localparam int SVB = 4;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;
  localparam int SFT = SHT * SVT;

  typedef struct {
    int h;
    int v;
    int rdx;
    int rdy;
    int hs;
    int bn;
    int rgb;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] f_pix, s_pix;
  logic [7:0] f_rdx, s_rdx;
  logic [6:0] f_rdy, s_rdy;
  logic [2:0] f_rgb, s_rgb;
  logic       f_hs, s_hs, f_vs, s_vs;
  logic       f_bn, s_bn, f_vb, s_vb;
  logic       f_fd, s_fd;

  int   tests = 0;
  int   fails = 0;
  int   k;
  bit   chk_en = 1'b0;
  bit   force7 = 1'b0;
  logic [2:0] img [0:7][0:15];

  vec_t tbl [13];
  int   t_fall, t_rise, t_fall2, bcnt, n, len, fd_cnt;
  logic prev;

  always #5 clk = ~clk;

  vga_frame_reader u_full (
    .clk(clk), .rst(rst), .pix_din(f_pix),
    .rd_x_addr(f_rdx), .rd_y_addr(f_rdy),
    .vga_rgb(f_rgb), .vga_hs(f_hs), .vga_vs(f_vs),
    .vga_blank_n(f_bn), .vblank(f_vb), .frame_done(f_fd)
  );

  vga_frame_reader #(
    .CLK_DIV(SD),
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .SCALE_SHIFT(2)
  ) u_small (
    .clk(clk), .rst(rst), .pix_din(s_pix),
    .rd_x_addr(s_rdx), .rd_y_addr(s_rdy),
    .vga_rgb(s_rgb), .vga_hs(s_hs), .vga_vs(s_vs),
    .vga_blank_n(s_bn), .vblank(s_vb), .frame_done(s_fd)
  );

  // RAM models, 1 clk read latency.
  always @(posedge clk) f_pix <= 3'(f_rdx) + 3'(f_rdy);
  always @(posedge clk)
    s_pix <= force7 ? 3'd7 : img[int'(s_rdy)][int'(s_rdx)];

  // Clocks since the last reset edge.
  always @(posedge clk) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got %0d, want %0d (k=%0d)",
                 name, act, exp, k);
    end
  endtask

  // Expected small-instance outputs from the tick count alone.
  task automatic model_check();
    int  tn, h, v, q, hq, vq;
    bit  act, actq;
    tn  = k / SD;
    h   = tn % SHT;
    v   = (tn / SHT) % SVT;
    act = (h < SHA) && (v < SVA);
    chk("s_rdx", s_rdx, act ? h / 4 : 0);
    chk("s_rdy", s_rdy, act ? v / 4 : 0);
    chk("s_vblank", s_vb, v >= SVA);
    chk("s_frame_done", s_fd,
        (k % SD == 0) && (tn % SFT == SHT * SVA));
    if (tn == 0) begin
      chk("s_hs", s_hs, 1);
      chk("s_vs", s_vs, 1);
      chk("s_blank_n", s_bn, 0);
      chk("s_rgb", s_rgb, 0);
    end else begin
      q    = tn - 1;
      hq   = q % SHT;
      vq   = (q / SHT) % SVT;
      actq = (hq < SHA) && (vq < SVA);
      chk("s_hs", s_hs,
          !(hq >= SHA + SHF && hq < SHA + SHF + SHS));
      chk("s_vs", s_vs,
          !(vq >= SVA + SVF && vq < SVA + SVF + SVS));
      chk("s_blank_n", s_bn, actq);
      chk("s_rgb", s_rgb,
          !actq ? 0 : force7 ? 7 : img[vq / 4][hq / 4]);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) model_check();
  end

  task automatic reset_with(input int cyc, input bit f7);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    force7 = f7;
    foreach (img[y, x]) img[y][x] = 3'($urandom_range(0, 7));
    repeat (cyc - 1) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL timeout: sim did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{0,   0, 0,   0, 1, 1, 0};
    tbl[1]  = '{5,   0, 1,   0, 1, 1, 1};
    tbl[2]  = '{639, 0, 159, 0, 1, 1, 7};
    tbl[3]  = '{640, 0, 0,   0, 1, 0, 0};
    tbl[4]  = '{655, 0, 0,   0, 1, 0, 0};
    tbl[5]  = '{656, 0, 0,   0, 0, 0, 0};
    tbl[6]  = '{751, 0, 0,   0, 0, 0, 0};
    tbl[7]  = '{752, 0, 0,   0, 1, 0, 0};
    tbl[8]  = '{799, 0, 0,   0, 1, 0, 0};
    tbl[9]  = '{100, 3, 25,  0, 1, 1, 1};
    tbl[10] = '{4,   8, 1,   2, 1, 1, 3};
    tbl[11] = '{7,   8, 1,   2, 1, 1, 3};
    tbl[12] = '{8,   8, 2,   2, 1, 1, 4};
    foreach (img[y, x]) img[y][x] = 3'($urandom_range(0, 7));

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_hs", f_hs, 1);
    chk("rst_vs", f_vs, 1);
    chk("rst_rgb", f_rgb, 0);
    chk("rst_blank_n", f_bn, 0);
    chk("rst_rdx", f_rdx, 0);
    chk("rst_rdy", f_rdy, 0);
    chk("rst_frame_done", f_fd, 0);
    chk("rst_vblank", f_vb, 0);
    rst = 1'b0;

    t_fall  = -1;
    t_rise  = -1;
    t_fall2 = -1;
    bcnt    = 0;
    prev    = f_hs;
    while (k < 3300) begin
      @(negedge clk);
      if (prev && !f_hs) begin
        if (t_fall < 0) t_fall = k;
        else if (t_fall2 < 0) t_fall2 = k;
      end
      if (!prev && f_hs && t_rise < 0) t_rise = k;
      if (k >= 1600 && k < 3200 && f_bn) bcnt++;
      prev = f_hs;
    end
    chk("hs_first_fall", t_fall, 657 * FD);
    chk("hs_low_width", t_rise - t_fall, 96 * FD);
    chk("hs_period", t_fall2 - t_fall, 800 * FD);
    chk("blank_n_per_line", bcnt, 640 * FD);

    reset_with(2, 1'b0);
    for (int i = 0; i < 13; i++) begin
      n = tbl[i].v * 800 + tbl[i].h;
      while (k < n * FD) @(negedge clk);
      chk("tbl_rdx", f_rdx, tbl[i].rdx);
      chk("tbl_rdy", f_rdy, tbl[i].rdy);
      while (k < (n + 1) * FD) @(negedge clk);
      chk("tbl_hs", f_hs, tbl[i].hs);
      chk("tbl_blank_n", f_bn, tbl[i].bn);
      chk("tbl_rgb", f_rgb, tbl[i].rgb);
      chk("tbl_vs", f_vs, 1);
    end

    reset_with(1, 1'b0);
    while (k < (10 * SHT + 30) * SD) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_k", k, 0);
    chk("mid_s_hs", s_hs, 1);
    chk("mid_s_blank_n", s_bn, 0);
    chk("mid_s_rgb", s_rgb, 0);
    chk("mid_f_hs", f_hs, 1);
    chk("mid_f_blank_n", f_bn, 0);
    chk("mid_f_rgb", f_rgb, 0);
    while (s_hs && k < 1000) @(negedge clk);
    chk("mid_s_first_hs_fall", k, (SHA + SHF + 1) * SD);
    while (f_hs && k < 3000) @(negedge clk);
    chk("mid_f_first_hs_fall", k, 657 * FD);

    for (int s = 0; s < 5; s++) begin
      len = (s == 0) ? 20000 : $urandom_range(300, 4000);
      reset_with($urandom_range(1, 4), (s % 2) == 1);
      fd_cnt = 0;
      repeat (len) begin
        @(negedge clk);
        if (s_fd) fd_cnt++;
      end
      if (s == 0) chk("frame_done_count", fd_cnt, 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
